// File: rtl/weight_read_sequencer_pkg.sv
// Shared types and helpers for the weight-BRAM read sequencer and its siblings.
// Holds state encoding, channel-group constants and small sizing helpers.
package weight_read_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_WAIT = 3'd1,
        ST_CALC      = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_e;

    // Number of address bits needed to index 'depth' entries.
    function automatic int getasize(input int unsigned depth);
        int bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < depth) bits = i + 1;
        end
        return bits;
    endfunction

    localparam int CH_IN_LOG2  = getasize(16);
    localparam int CH_OUT_LOG2 = getasize(32);

    // ceil(n / 2**lg)
    function automatic logic [63:0] ceil_to_group(input logic [63:0] n, input int lg);
        logic [63:0] mask;
        mask = (64'd1 << lg) - 64'd1;
        return (n + mask) >> lg;
    endfunction

endpackage

// File: rtl/weight_read_sequencer_edge.sv
// Rising-edge detector for a level start request: two sampling flops plus a
// registered single-cycle pulse. Shared with the weight loader.
module seq_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic pulse_o
);

    logic sync_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= level_i;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/weight_read_sequencer.sv
// Read-side address generator for the double-buffered weight BRAM: walks
// co-group (outer), kernel position (middle), ci-group (inner) after load-done.
module weight_read_sequencer
    import weight_read_sequencer_pkg::*;
#(
    parameter int LITEWIDTH   = 32,
    parameter int CH_IN       = 16,
    parameter int CH_OUT      = 32,
    parameter int KWIDTH      = 4,
    parameter int COWIDTH     = 10,
    parameter int WBRAM_DEPTH = 512
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_ap_start,
    input  logic [LITEWIDTH-1:0] I_ci_num,
    input  logic [LITEWIDTH-1:0] I_co_num,
    input  logic [LITEWIDTH-1:0] I_kxk_num,
    input  logic                 I_load_done,
    input  logic                 I_pe_ready,
    output logic [COWIDTH-2:0]   O_rd_wdepth,
    output logic                 O_rd_dv,
    output logic                 O_acc_first,
    output logic                 O_acc_last,
    output logic [COWIDTH-6:0]   O_cog_idx,
    output logic                 O_busy,
    output logic                 O_done,
    output logic                 O_err
);

    localparam int GW    = COWIDTH - 4;
    localparam int CW    = COWIDTH - 5;
    localparam int PW    = 2 * COWIDTH;
    localparam int CI_LG = getasize(CH_IN);
    localparam int CO_LG = getasize(CH_OUT);

    // Group counters and k counter have fixed widths; larger configs are rejected.
    localparam logic [63:0] GMAX = (64'd1 << GW) - 64'd1;
    localparam logic [63:0] KMAX = 64'd1 << KWIDTH;

    logic start_pulse;

    seq_edge_detect u_start_edge (
        .clk_i   (I_clk),
        .rst_ni  (I_rst_n),
        .level_i (I_ap_start),
        .pulse_o (start_pulse)
    );

    logic [63:0]   cig_cnt_d;
    logic [63:0]   cog_cnt_d;
    logic [63:0]   kxk_d;
    logic [PW-1:0] stride_d;
    logic [PW-1:0] total_d;
    logic          cfg_zero_d;
    logic          cfg_ovf_d;

    always_comb begin
        cig_cnt_d  = ceil_to_group(64'(I_ci_num), CI_LG);
        cog_cnt_d  = ceil_to_group(64'(I_co_num), CO_LG);
        kxk_d      = 64'(I_kxk_num);
        stride_d   = PW'(cig_cnt_d[GW-1:0]) * PW'(cog_cnt_d[GW-1:0]);
        total_d    = stride_d * PW'(kxk_d[KWIDTH:0]);
        cfg_zero_d = (I_ci_num == '0) || (I_co_num == '0) || (I_kxk_num == '0);
        cfg_ovf_d  = (cig_cnt_d > GMAX) || (cog_cnt_d > GMAX) || (kxk_d > KMAX)
                     || (total_d > PW'(WBRAM_DEPTH));
    end

    seq_state_e          state_q;
    logic [COWIDTH-1:0]  addr_q;
    logic [COWIDTH-1:0]  kbase_q;
    logic [COWIDTH-1:0]  stride_q;
    logic [GW-1:0]       cog_step_q;
    logic [GW-1:0]       cig_q;
    logic [GW-1:0]       cog_q;
    logic [GW-1:0]       cigmax_q;
    logic [GW-1:0]       cogmax_q;
    logic [KWIDTH-1:0]   k_q;
    logic [KWIDTH-1:0]   kmax_q;
    logic                dv_q;
    logic                first_q;
    logic                last_q;
    logic [CW-1:0]       cogidx_q;
    logic                done_q;
    logic                err_q;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            kbase_q    <= '0;
            stride_q   <= '0;
            cog_step_q <= '0;
            cig_q      <= '0;
            cog_q      <= '0;
            cigmax_q   <= '0;
            cogmax_q   <= '0;
            k_q        <= '0;
            kmax_q     <= '0;
            dv_q       <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            cogidx_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dv_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            if (start_pulse) begin
                // Restart from any state; an in-flight valid already left this cycle.
                state_q <= ST_LOAD_WAIT;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                addr_q  <= '0;
                kbase_q <= '0;
                cig_q   <= '0;
                cog_q   <= '0;
                k_q     <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_LOAD_WAIT: begin
                        if (I_load_done) state_q <= ST_CALC;
                    end
                    ST_CALC: begin
                        stride_q   <= stride_d[COWIDTH-1:0];
                        cog_step_q <= cog_cnt_d[GW-1:0];
                        cigmax_q   <= cig_cnt_d[GW-1:0] - GW'(1);
                        cogmax_q   <= cog_cnt_d[GW-1:0] - GW'(1);
                        kmax_q     <= kxk_d[KWIDTH-1:0] - KWIDTH'(1);
                        if (cfg_zero_d) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (cfg_ovf_d) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (I_pe_ready) begin
                            dv_q     <= 1'b1;
                            first_q  <= (k_q == '0) && (cig_q == '0);
                            last_q   <= (k_q == kmax_q) && (cig_q == cigmax_q);
                            cogidx_q <= cog_q[CW-1:0];
                            // Incremental depth = k*stride + cig*coG + cog.
                            if (cig_q != cigmax_q) begin
                                cig_q  <= cig_q + GW'(1);
                                addr_q <= addr_q + COWIDTH'(cog_step_q);
                            end else if (k_q != kmax_q) begin
                                cig_q   <= '0;
                                k_q     <= k_q + KWIDTH'(1);
                                kbase_q <= kbase_q + stride_q;
                                addr_q  <= kbase_q + stride_q;
                            end else if (cog_q != cogmax_q) begin
                                cig_q   <= '0;
                                k_q     <= '0;
                                cog_q   <= cog_q + GW'(1);
                                kbase_q <= COWIDTH'(cog_q) + COWIDTH'(1);
                                addr_q  <= COWIDTH'(cog_q) + COWIDTH'(1);
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign O_rd_wdepth = addr_q[COWIDTH-2:0];
    assign O_rd_dv     = dv_q;
    assign O_acc_first = first_q;
    assign O_acc_last  = last_q;
    assign O_cog_idx   = cogidx_q;
    assign O_busy      = (state_q == ST_LOAD_WAIT) || (state_q == ST_CALC) || (state_q == ST_RUN);
    assign O_done      = done_q;
    assign O_err       = err_q;

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed bench for weight_read_sequencer: logs every valid word and compares
// against hand-computed address/marker tables.
module tb_weight_read_sequencer;

    localparam int COWIDTH = 10;

    logic                I_clk = 1'b0;
    logic                I_rst_n;
    logic                I_ap_start;
    logic [31:0]         I_ci_num;
    logic [31:0]         I_co_num;
    logic [31:0]         I_kxk_num;
    logic                I_load_done;
    logic                I_pe_ready;
    logic [COWIDTH-2:0]  O_rd_wdepth;
    logic                O_rd_dv;
    logic                O_acc_first;
    logic                O_acc_last;
    logic [COWIDTH-6:0]  O_cog_idx;
    logic                O_busy;
    logic                O_done;
    logic                O_err;

    weight_read_sequencer dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_ap_start  (I_ap_start),
        .I_ci_num    (I_ci_num),
        .I_co_num    (I_co_num),
        .I_kxk_num   (I_kxk_num),
        .I_load_done (I_load_done),
        .I_pe_ready  (I_pe_ready),
        .O_rd_wdepth (O_rd_wdepth),
        .O_rd_dv     (O_rd_dv),
        .O_acc_first (O_acc_first),
        .O_acc_last  (O_acc_last),
        .O_cog_idx   (O_cog_idx),
        .O_busy      (O_busy),
        .O_done      (O_done),
        .O_err       (O_err)
    );

    always #5 I_clk = ~I_clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Valid-word log: the address shown during the issue cycle is paired with
    // the valid that follows it.
    int                 log_n = 0;
    int                 orphan = 0;
    logic [COWIDTH-2:0] log_addr  [0:511];
    logic [COWIDTH-6:0] log_cog   [0:511];
    logic               log_first [0:511];
    logic               log_last  [0:511];
    logic               log_done  [0:511];
    logic               prev_ready = 1'b0;
    logic [COWIDTH-2:0] prev_addr = '0;

    always @(negedge I_clk) begin
        if (O_rd_dv) begin
            if (log_n < 512) begin
                log_addr[log_n]  <= prev_addr;
                log_cog[log_n]   <= O_cog_idx;
                log_first[log_n] <= O_acc_first;
                log_last[log_n]  <= O_acc_last;
                log_done[log_n]  <= O_done;
            end
            log_n <= log_n + 1;
            if (!prev_ready) orphan <= orphan + 1;
        end
        prev_ready <= I_pe_ready;
        prev_addr  <= O_rd_wdepth;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge I_clk);
        #1;
    endtask

    task automatic start_layer(input int ci, input int co, input int kxk, input bit ld);
        I_ci_num    = 32'(ci);
        I_co_num    = 32'(co);
        I_kxk_num   = 32'(kxk);
        I_load_done = 1'b0;
        I_ap_start  = 1'b1;
        tick(4);
        I_ap_start  = 1'b0;
        I_load_done = ld;
    endtask

    task automatic wait_end(input int mode);
        int         c;
        bit         hit;
        logic [3:0] rdy_pat;
        rdy_pat = 4'b1001;
        c   = 0;
        hit = 1'b0;
        while (!hit && c < 400) begin
            if (O_done || O_err) hit = 1'b1;
            else begin
                I_pe_ready = (mode == 0) ? 1'b1 : rdy_pat[c % 4];
                tick(1);
                c++;
            end
        end
        chk("end_reached", 64'(hit), 1);
        I_pe_ready = 1'b1;
        tick(2);
    endtask

    task automatic check_log(input string tag, input int base, input int n,
                             input int ea[9], input int ec[9], input int ef[9], input int el[9]);
        chk({tag, "_count"}, 64'(log_n - base), 64'(n));
        for (int i = 0; i < n && i < log_n - base; i++) begin
            chk($sformatf("%s_addr%0d", tag, i),  64'(log_addr[base+i]),  64'(ea[i]));
            chk($sformatf("%s_cog%0d", tag, i),   64'(log_cog[base+i]),   64'(ec[i]));
            chk($sformatf("%s_first%0d", tag, i), 64'(log_first[base+i]), 64'(ef[i]));
            chk($sformatf("%s_last%0d", tag, i),  64'(log_last[base+i]),  64'(el[i]));
            chk($sformatf("%s_done%0d", tag, i),  64'(log_done[base+i]),  64'(i == n - 1));
        end
    endtask

    int ea1[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    int ec1[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int ef1[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    int el1[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int ea2[9] = '{0, 2, 4, 1, 3, 5, 0, 0, 0};
    int ec2[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int ef2[9] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
    int el2[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};

    initial begin
        int base;
        int lat;
        int guard;

        I_rst_n     = 1'b0;
        I_ap_start  = 1'b0;
        I_ci_num    = '0;
        I_co_num    = '0;
        I_kxk_num   = '0;
        I_load_done = 1'b0;
        I_pe_ready  = 1'b1;
        tick(3);
        chk("rst_dv", 64'(O_rd_dv), 0);
        chk("rst_addr", 64'(O_rd_wdepth), 0);
        chk("rst_flags", 64'({O_acc_first, O_acc_last, O_busy, O_done, O_err}), 0);
        chk("rst_cog", 64'(O_cog_idx), 0);
        @(negedge I_clk);
        I_rst_n = 1'b1;
        tick(2);

        // 1: single group, nine kernel positions, back-to-back
        base = log_n;
        start_layer(16, 32, 9, 1'b1);
        wait_end(0);
        check_log("t1", base, 9, ea1, ec1, ef1, el1);
        chk("t1_done", 64'(O_done), 1);
        chk("t1_err", 64'(O_err), 0);
        chk("t1_busy", 64'(O_busy), 0);

        // 2: ciG=3, coG=2, kxk=1
        base = log_n;
        start_layer(40, 64, 1, 1'b1);
        wait_end(0);
        check_log("t2", base, 6, ea2, ec2, ef2, el2);

        // 3: ready toggled 1,0,0,1
        base = log_n;
        start_layer(16, 32, 9, 1'b1);
        wait_end(1);
        check_log("t3", base, 9, ea1, ec1, ef1, el1);

        // 4a: zero kernel positions
        base = log_n;
        start_layer(16, 32, 0, 1'b0);
        chk("t4_done_cleared", 64'(O_done), 0);
        I_load_done = 1'b1;
        lat = 0;
        while (!O_done && lat < 10) begin
            tick(1);
            lat++;
        end
        chk("t4_lat_le3", 64'(lat <= 3), 1);
        tick(2);
        chk("t4_dv_count", 64'(log_n - base), 0);
        chk("t4_done", 64'(O_done), 1);
        chk("t4_err", 64'(O_err), 0);

        // 4b: total 9216 exceeds the BRAM
        base = log_n;
        start_layer(512, 1023, 9, 1'b1);
        wait_end(0);
        chk("t4b_err", 64'(O_err), 1);
        chk("t4b_done", 64'(O_done), 0);
        chk("t4b_dv_count", 64'(log_n - base), 0);

        // 5: restart mid-run after four issues
        base = log_n;
        start_layer(16, 32, 9, 1'b1);
        I_pe_ready = 1'b1;
        guard = 0;
        while (log_n - base < 4 && guard < 50) begin
            tick(1);
            guard++;
        end
        chk("t5_reached4", 64'(log_n - base >= 4), 1);
        I_load_done = 1'b0;
        I_ap_start  = 1'b1;
        tick(6);
        I_ap_start  = 1'b0;
        chk("t5_busy_wait", 64'(O_busy), 1);
        chk("t5_not_done", 64'(O_done), 0);
        base = log_n;
        tick(5);
        chk("t5_no_dv_wait", 64'(log_n - base), 0);
        I_load_done = 1'b1;
        wait_end(0);
        check_log("t5", base, 9, ea1, ec1, ef1, el1);

        // 6: asynchronous reset mid-run
        base = log_n;
        start_layer(16, 32, 9, 1'b1);
        guard = 0;
        while (log_n - base < 3 && guard < 50) begin
            tick(1);
            guard++;
        end
        @(negedge I_clk);
        I_rst_n = 1'b0;
        #1;
        chk("t6_async_dv", 64'(O_rd_dv), 0);
        chk("t6_async_addr", 64'(O_rd_wdepth), 0);
        chk("t6_async_flags", 64'({O_acc_first, O_acc_last, O_busy, O_done, O_err}), 0);
        @(posedge I_clk);
        @(negedge I_clk);
        I_rst_n = 1'b1;
        tick(1);
        base = log_n;
        tick(8);
        chk("t6_no_dv", 64'(log_n - base), 0);
        chk("t6_idle_busy", 64'(O_busy), 0);
        chk("t6_idle_done", 64'(O_done), 0);

        chk("orphan_dv", 64'(orphan), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
